// File: rtl/nor_1_bit_checker.sv
// Response checker for the nor_1_bit test flow: samples dut_c a fixed delay after
// each strobed vector, compares against ~(a|b), and tracks counts and coverage.
module nor_1_bit_checker #(
    parameter int CNT_W      = 8,
    parameter int SAMPLE_DLY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_vec,
    output logic             overrun
);

    localparam int DLY_W = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = (SAMPLE_DLY > 0) ? DLY_W'(SAMPLE_DLY - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT, S_DONE} state_t;

    state_t           state, state_n;
    logic [DLY_W-1:0] dly;
    logic [1:0]       pend_vec;
    logic             cmp_en;
    logic [1:0]       cmp_vec;
    logic             cmp_exp;
    logic             cmp_bad;
    logic [3:0]       cov_next;
    logic             all_cov;
    logic             ovr_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        cmp_en  = 1'b0;
        cmp_vec = pend_vec;
        case (state)
            S_IDLE:  if (start) state_n = S_ARMED;
            S_ARMED: begin
                if (start) begin
                    state_n = S_ARMED;
                end else if (in_valid) begin
                    if (SAMPLE_DLY == 0) begin
                        cmp_en  = 1'b1;
                        cmp_vec = {in_b, in_a};
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (start) begin
                    state_n = S_ARMED;
                end else if (dly == '0) begin
                    cmp_en  = 1'b1;
                    state_n = S_ARMED;
                end
            end
            S_DONE:  if (start) state_n = S_ARMED;
            default: state_n = S_IDLE;
        endcase
        // 4-state compare so an X/Z on dut_c is counted as a mismatch
        cmp_exp  = ~(cmp_vec[0] | cmp_vec[1]);
        cmp_bad  = (dut_c !== cmp_exp);
        cov_next = cov | (4'b0001 << cmp_vec);
        all_cov  = &cov_next;
        ovr_now  = (state == S_WAIT) && in_valid && !start;
        if (cmp_en && all_cov) state_n = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly            <= '0;
            pend_vec       <= '0;
            vec_cnt        <= '0;
            err_cnt        <= '0;
            cov            <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            overrun        <= 1'b0;
            pass           <= 1'b0;
        end else if (start) begin
            dly            <= '0;
            pend_vec       <= '0;
            vec_cnt        <= '0;
            err_cnt        <= '0;
            cov            <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            overrun        <= 1'b0;
            pass           <= 1'b0;
        end else begin
            if (state == S_ARMED && in_valid) begin
                pend_vec <= {in_b, in_a};
                dly      <= DLY_LOAD;
            end else if (state == S_WAIT && dly != '0) begin
                dly <= dly - 1'b1;
            end
            if (ovr_now) overrun <= 1'b1;
            if (cmp_en) begin
                if (vec_cnt != '1) vec_cnt <= vec_cnt + 1'b1;
                cov <= cov_next;
                if (cmp_bad) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                    if (!first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_vec <= cmp_vec;
                    end
                end
                if (all_cov) pass <= (err_cnt == '0) && !cmp_bad && !overrun && !ovr_now;
            end
        end
    end

    assign busy = (state == S_ARMED) || (state == S_WAIT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_nor_1_bit_checker.sv
// Directed bench for nor_1_bit_checker: four parameterisations share stimulus,
// a behavioural NOR model with selectable delay/fault drives dut_c.
module tb_nor_1_bit_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_a = 1'b0;
    logic in_b = 1'b0;
    logic m_c;
    int   total = 0;
    int   bad = 0;

    int        mdl_dly = 1;
    int        mdl_fault = 0;
    logic [3:0] h;

    always #5 clk = ~clk;

    always_ff @(posedge clk) h <= {h[2:0], ~(in_a | in_b)};

    always_comb begin
        m_c = ~(in_a | in_b);
        case (mdl_dly)
            1: m_c = h[0];
            2: m_c = h[1];
            3: m_c = h[2];
            default: m_c = ~(in_a | in_b);
        endcase
        if (mdl_fault == 1) m_c = 1'b0;
        if (mdl_fault == 2) m_c = 1'b1;
    end

    logic a_busy, a_done, a_pass, a_ffv, a_ovr;
    logic [7:0] a_vec, a_err;
    logic [3:0] a_cov;
    logic [1:0] a_ffvec;
    nor_1_bit_checker #(.CNT_W(8), .SAMPLE_DLY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .dut_c(m_c), .busy(a_busy), .done(a_done), .pass(a_pass), .vec_cnt(a_vec), .err_cnt(a_err),
        .cov(a_cov), .first_fail_vld(a_ffv), .first_fail_vec(a_ffvec), .overrun(a_ovr));

    logic b_busy, b_done, b_pass, b_ffv, b_ovr;
    logic [7:0] b_vec, b_err;
    logic [3:0] b_cov;
    logic [1:0] b_ffvec;
    nor_1_bit_checker #(.CNT_W(8), .SAMPLE_DLY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .dut_c(m_c), .busy(b_busy), .done(b_done), .pass(b_pass), .vec_cnt(b_vec), .err_cnt(b_err),
        .cov(b_cov), .first_fail_vld(b_ffv), .first_fail_vec(b_ffvec), .overrun(b_ovr));

    logic c_busy, c_done, c_pass, c_ffv, c_ovr;
    logic [7:0] c_vec, c_err;
    logic [3:0] c_cov;
    logic [1:0] c_ffvec;
    nor_1_bit_checker #(.CNT_W(8), .SAMPLE_DLY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .dut_c(m_c), .busy(c_busy), .done(c_done), .pass(c_pass), .vec_cnt(c_vec), .err_cnt(c_err),
        .cov(c_cov), .first_fail_vld(c_ffv), .first_fail_vec(c_ffvec), .overrun(c_ovr));

    logic d_busy, d_done, d_pass, d_ffv, d_ovr;
    logic [1:0] d_vec, d_err;
    logic [3:0] d_cov;
    logic [1:0] d_ffvec;
    nor_1_bit_checker #(.CNT_W(2), .SAMPLE_DLY(1)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .dut_c(m_c), .busy(d_busy), .done(d_done), .pass(d_pass), .vec_cnt(d_vec), .err_cnt(d_err),
        .cov(d_cov), .first_fail_vld(d_ffv), .first_fail_vec(d_ffvec), .overrun(d_ovr));

    // all stimulus tasks enter and leave on a falling edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] v, input logic [1:0] nxt, input int gap);
        {in_b, in_a} = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        {in_b, in_a} = nxt;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", a_done); end
        total++; if (a_pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", a_pass); end
        total++; if (a_vec !== 8'd0) begin bad++; $display("FAIL reset_vec got=%0d exp=0", a_vec); end
        total++; if (a_cov !== 4'h0) begin bad++; $display("FAIL reset_cov got=%h exp=0", a_cov); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_nor();
        mdl_dly = 1; mdl_fault = 0;
        pulse_start();
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL good_busy got=%b exp=1", a_busy); end
        send(2'b00, 2'b01, 2);
        send(2'b01, 2'b10, 2);
        send(2'b10, 2'b11, 2);
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL good_early_done got=%b exp=0", a_done); end
        send(2'b11, 2'b11, 2);
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL good_done got=%b exp=1", a_done); end
        total++; if (a_pass !== 1'b1) begin bad++; $display("FAIL good_pass got=%b exp=1", a_pass); end
        total++; if (a_vec !== 8'd4) begin bad++; $display("FAIL good_vec got=%0d exp=4", a_vec); end
        total++; if (a_err !== 8'd0) begin bad++; $display("FAIL good_err got=%0d exp=0", a_err); end
        total++; if (a_cov !== 4'hF) begin bad++; $display("FAIL good_cov got=%h exp=f", a_cov); end
        total++; if (a_ffv !== 1'b0) begin bad++; $display("FAIL good_ffv got=%b exp=0", a_ffv); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL good_busy_end got=%b exp=0", a_busy); end
    endtask

    task automatic test_stuck0();
        mdl_dly = 1; mdl_fault = 1;
        pulse_start();
        total++; if (a_done !== 1'b0 || a_vec !== 8'd0) begin bad++; $display("FAIL stuck_clear got=%b/%0d exp=0/0", a_done, a_vec); end
        send(2'b00, 2'b01, 2);
        send(2'b01, 2'b10, 2);
        send(2'b10, 2'b11, 2);
        send(2'b11, 2'b11, 2);
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL stuck_done got=%b exp=1", a_done); end
        total++; if (a_pass !== 1'b0) begin bad++; $display("FAIL stuck_pass got=%b exp=0", a_pass); end
        total++; if (a_err !== 8'd1) begin bad++; $display("FAIL stuck_err got=%0d exp=1", a_err); end
        total++; if (a_ffv !== 1'b1) begin bad++; $display("FAIL stuck_ffv got=%b exp=1", a_ffv); end
        total++; if (a_ffvec !== 2'b00) begin bad++; $display("FAIL stuck_ffvec got=%b exp=00", a_ffvec); end
        total++; if (a_vec !== 8'd4) begin bad++; $display("FAIL stuck_vec got=%0d exp=4", a_vec); end
    endtask

    task automatic run_dly3_seq();
        pulse_start();
        send(2'b00, 2'b00, 4);
        send(2'b00, 2'b01, 4);
        send(2'b01, 2'b10, 4);
        send(2'b10, 2'b11, 4);
        send(2'b11, 2'b11, 4);
    endtask

    task automatic test_delay3();
        mdl_fault = 0; mdl_dly = 3;
        run_dly3_seq();
        total++; if (b_done !== 1'b1) begin bad++; $display("FAIL d3_done got=%b exp=1", b_done); end
        total++; if (b_vec !== 8'd5) begin bad++; $display("FAIL d3_vec got=%0d exp=5", b_vec); end
        total++; if (b_cov !== 4'hF) begin bad++; $display("FAIL d3_cov got=%h exp=f", b_cov); end
        total++; if (b_pass !== 1'b1) begin bad++; $display("FAIL d3_pass got=%b exp=1", b_pass); end
        total++; if (b_err !== 8'd0) begin bad++; $display("FAIL d3_err got=%0d exp=0", b_err); end
        mdl_dly = 2;
        run_dly3_seq();
        total++; if (b_err !== 8'd1) begin bad++; $display("FAIL d3_late_err got=%0d exp=1", b_err); end
        total++; if (b_pass !== 1'b0) begin bad++; $display("FAIL d3_late_pass got=%b exp=0", b_pass); end
        total++; if (b_ffvec !== 2'b00) begin bad++; $display("FAIL d3_late_ffvec got=%b exp=00", b_ffvec); end
    endtask

    task automatic test_back_to_back();
        mdl_fault = 0; mdl_dly = 2;
        pulse_start();
        {in_b, in_a} = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        {in_b, in_a} = 2'b01; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (c_ovr !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b exp=1", c_ovr); end
        total++; if (c_vec !== 8'd1) begin bad++; $display("FAIL b2b_vec1 got=%0d exp=1", c_vec); end
        send(2'b01, 2'b10, 3);
        send(2'b10, 2'b11, 3);
        send(2'b11, 2'b11, 3);
        total++; if (c_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", c_done); end
        total++; if (c_vec !== 8'd4) begin bad++; $display("FAIL b2b_vec got=%0d exp=4", c_vec); end
        total++; if (c_err !== 8'd0) begin bad++; $display("FAIL b2b_err got=%0d exp=0", c_err); end
        total++; if (c_pass !== 1'b0) begin bad++; $display("FAIL b2b_pass got=%b exp=0", c_pass); end
    endtask

    task automatic test_reset_in_wait();
        mdl_fault = 0; mdl_dly = 3;
        pulse_start();
        send(2'b00, 2'b01, 4);
        send(2'b01, 2'b10, 4);
        total++; if (b_vec !== 8'd2) begin bad++; $display("FAIL rw_vec_pre got=%0d exp=2", b_vec); end
        {in_b, in_a} = 2'b10; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL rw_busy_pre got=%b exp=1", b_busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL rw_busy got=%b exp=0", b_busy); end
        total++; if (b_vec !== 8'd0) begin bad++; $display("FAIL rw_vec got=%0d exp=0", b_vec); end
        total++; if (b_cov !== 4'h0) begin bad++; $display("FAIL rw_cov got=%h exp=0", b_cov); end
        total++; if ({b_done, b_pass, b_ffv, b_ovr, b_ffvec} !== 6'b0) begin bad++; $display("FAIL rw_flags got=%b exp=000000", {b_done, b_pass, b_ffv, b_ovr, b_ffvec}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'b00, 2'b00, 5);
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL rw_idle_busy got=%b exp=0", b_busy); end
        total++; if (b_vec !== 8'd0) begin bad++; $display("FAIL rw_idle_vec got=%0d exp=0", b_vec); end
    endtask

    task automatic test_saturate();
        mdl_dly = 1; mdl_fault = 2;
        pulse_start();
        for (int i = 0; i < 5; i++) send(2'b01, 2'b01, 2);
        total++; if (d_err !== 2'd3) begin bad++; $display("FAIL sat_err got=%0d exp=3", d_err); end
        total++; if (d_vec !== 2'd3) begin bad++; $display("FAIL sat_vec got=%0d exp=3", d_vec); end
        total++; if (d_ffv !== 1'b1 || d_ffvec !== 2'b01) begin bad++; $display("FAIL sat_ff got=%b/%b exp=1/01", d_ffv, d_ffvec); end
        total++; if (d_cov !== 4'b0010) begin bad++; $display("FAIL sat_cov got=%b exp=0010", d_cov); end
        total++; if (d_done !== 1'b0) begin bad++; $display("FAIL sat_done got=%b exp=0", d_done); end
        start = 1'b1; in_valid = 1'b1; {in_b, in_a} = 2'b01;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        total++; if (d_vec !== 2'd0 || d_err !== 2'd0) begin bad++; $display("FAIL sv_clear got=%0d/%0d exp=0/0", d_vec, d_err); end
        total++; if (d_ffv !== 1'b0) begin bad++; $display("FAIL sv_ffv got=%b exp=0", d_ffv); end
        repeat (3) @(negedge clk);
        total++; if (d_vec !== 2'd0) begin bad++; $display("FAIL sv_notlatched got=%0d exp=0", d_vec); end
        total++; if (d_cov !== 4'h0) begin bad++; $display("FAIL sv_cov got=%b exp=0000", d_cov); end
        total++; if (d_busy !== 1'b1) begin bad++; $display("FAIL sv_busy got=%b exp=1", d_busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_nor();
        test_stuck0();
        test_delay3();
        test_back_to_back();
        test_reset_in_wait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
